// File: rtl/rotate_right_seq_if.sv
// ---------------------------------------------------------------------------
// rotate_right_seq_if
// Handshake/data bundle between the datapath control unit and the multi-cycle
// right-rotate unit.
//   start  : request, sampled by the unit while it is not busy
//   A      : data to rotate
//   B      : rotate amount (only the low log2(WIDTH) bits matter)
//   result : rotated value, valid while done=1 and held afterwards
//   busy   : high while a rotation is in progress
//   done   : one-cycle pulse marking result valid
// master = control unit side, slave = rotate unit side.
// ---------------------------------------------------------------------------
interface rotate_right_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B,
        input  result, busy, done
    );

    modport slave (
        input  start, A, B,
        output result, busy, done
    );
endinterface

// File: rtl/rotate_right_seq.sv
// ---------------------------------------------------------------------------
// rotate_right_seq
// Multi-cycle right bit-rotation unit. The rotate amount is decomposed into
// power-of-two stages, one stage per clock, so the latency is fixed and does
// not depend on the amount.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset (priority over everything)
//   bus   : slave side of rotate_right_seq_if (start/A/B in,
//           result/busy/done out)
// Parameters:
//   WIDTH   : operand/result width, power of two
//   SHAMT_W : rotate-amount bits taken from B, equal to log2(WIDTH)
// ---------------------------------------------------------------------------
module rotate_right_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                clock,
    input  logic                reset,
    rotate_right_seq_if.slave   bus
);

    localparam int STAGE_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     data_r;
    logic [SHAMT_W-1:0]   amt_r;
    logic [STAGE_W-1:0]   stage;

    logic [31:0]          step;
    logic [WIDTH-1:0]     stage_rot;
    logic [WIDTH-1:0]     next_data;

    // Upper bits of B carry no meaning for the rotate amount.
    logic                 unused_b_upper;
    assign unused_b_upper = ^bus.B[WIDTH-1:SHAMT_W];

    // Rotation performed by the current stage: 2^stage positions, applied
    // only when the matching amount bit is set. step is never zero, so the
    // left shift amount stays below WIDTH.
    always_comb begin
        step      = 32'd1 << stage;
        stage_rot = (data_r >> step) | (data_r << (WIDTH - step));
        next_data = amt_r[stage] ? stage_rot : data_r;
    end

    // Control FSM with registered busy/done decodes. Accepting a request
    // latches the operands so later changes on A/B cannot disturb the
    // rotation in flight. DONE accepts a new start just like IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            data_r     <= '0;
            amt_r      <= '0;
            stage      <= '0;
            bus.result <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        data_r   <= bus.A;
                        amt_r    <= bus.B[SHAMT_W-1:0];
                        stage    <= '0;
                        bus.busy <= 1'b1;
                        state    <= ROTATE;
                    end
                end

                ROTATE: begin
                    data_r <= next_data;
                    if (stage == LAST_STAGE) begin
                        stage      <= '0;
                        bus.result <= next_data;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        stage <= stage + STAGE_W'(1);
                    end
                end

                DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        data_r   <= bus.A;
                        amt_r    <= bus.B[SHAMT_W-1:0];
                        stage    <= '0;
                        bus.busy <= 1'b1;
                        state    <= ROTATE;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

endmodule
